// File: rtl/irq_timer_if.sv
// Data-memory bus slice seen by the interval timer, plus its IRQ return line.
// Latency: ReadData is combinational, IRQ comes from registered state.
// Backpressure: none; the bus completes every access in the cycle it is presented.
interface irq_timer_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        IRQ;

    // CPU / bus side
    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, IRQ
    );

    // Timer side
    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, IRQ
    );
endinterface

// File: rtl/irq_timer.sv
// Memory-mapped interval timer: prescaled up-counter with reload on overflow and a latched interrupt.
// Latency: register writes visible the next cycle, reads same cycle, IRQ one edge after the overflow tick.
// Backpressure: none; every bus access completes in a single cycle.
module irq_timer #(
    parameter int unsigned PRESCALE = 1,
    parameter logic [31:0] BASE     = 32'h4000_0000
) (
    input  logic         clk,
    input  logic         reset,
    irq_timer_if.slave   bus
);

    localparam int unsigned     PW   = (PRESCALE > 1) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);

    // Architectural state
    logic [31:0]   th;
    logic [31:0]   tl;
    logic          en;
    logic          ie;
    logic          is;
    logic [7:0]    icnt;
    logic [PW-1:0] pcnt;

    // Next-state values
    logic [31:0]   th_n;
    logic [31:0]   tl_n;
    logic [2:0]    tcon_n;
    logic [7:0]    icnt_n;
    logic [PW-1:0] pcnt_n;

    // Decode: word offset relative to BASE; anything beyond four words is out of window
    logic [29:0]   word;
    logic          sel;
    logic [1:0]    off;
    logic          wr_th;
    logic          wr_tl;
    logic          wr_tcon;
    logic          wr_icnt;
    logic          tick;
    logic          ovf;
    logic          set_is;

    assign word    = bus.Address[31:2] - BASE[31:2];
    assign sel     = (word < 30'd4);
    assign off     = word[1:0];
    assign wr_th   = bus.MemWrite && sel && (off == 2'd0);
    assign wr_tl   = bus.MemWrite && sel && (off == 2'd1);
    assign wr_tcon = bus.MemWrite && sel && (off == 2'd2);
    assign wr_icnt = bus.MemWrite && sel && (off == 2'd3);

    // Tick is qualified by the current EN so a same-cycle EN clear still lets it land
    assign tick    = en && (pcnt == PMAX);
    assign ovf     = tick && (tl == 32'hFFFF_FFFF);

    assign bus.IRQ = ie & is;

    // Next-state computation with all collision rules resolved in one place
    always_comb begin
        th_n   = th;
        tl_n   = tl;
        tcon_n = {is, ie, en};
        icnt_n = icnt;
        set_is = 1'b0;

        if (wr_th) begin
            th_n = bus.WriteData;
        end

        // A bus write to TL overrides the increment/reload; reload uses the pre-write TH
        if (wr_tl) begin
            tl_n = bus.WriteData;
        end else if (tick) begin
            tl_n = ovf ? th : (tl + 32'd1);
        end

        if (wr_tcon) begin
            tcon_n = bus.WriteData[2:0];
        end

        // Overflow sets IS on top of any software clear so the interrupt is never dropped
        set_is = ovf && tcon_n[1];
        if (set_is) begin
            tcon_n[2] = 1'b1;
        end

        // Clear-then-increment: a clear coinciding with an event leaves the count at 1
        if (wr_icnt) begin
            icnt_n = 8'd0;
        end
        if (set_is && (icnt_n != 8'hFF)) begin
            icnt_n = icnt_n + 8'd1;
        end

        // Prescaler wraps on tick and is held at zero whenever EN is (or is becoming) low
        if (!en || !tcon_n[0] || tick) begin
            pcnt_n = '0;
        end else begin
            pcnt_n = pcnt + PW'(1);
        end
    end

    // State register with synchronous reset taking priority over bus and tick
    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= 32'd0;
            tl   <= 32'd0;
            en   <= 1'b0;
            ie   <= 1'b0;
            is   <= 1'b0;
            icnt <= 8'd0;
            pcnt <= '0;
        end else begin
            th   <= th_n;
            tl   <= tl_n;
            en   <= tcon_n[0];
            ie   <= tcon_n[1];
            is   <= tcon_n[2];
            icnt <= icnt_n;
            pcnt <= pcnt_n;
        end
    end

    // Zero-latency read mux; pre-write values are shown when read and write coincide
    always_comb begin
        bus.ReadData = 32'd0;
        if (bus.MemRead && sel) begin
            case (off)
                2'd0:    bus.ReadData = th;
                2'd1:    bus.ReadData = tl;
                2'd2:    bus.ReadData = {29'd0, is, ie, en};
                default: bus.ReadData = {24'd0, icnt};
            endcase
        end
    end

endmodule

// File: tb/tb_irq_timer.sv
// Bench for irq_timer: two instances (PRESCALE 1 and 4) share one stimulus stream.
// Each cycle both are compared against an arithmetic reference model; directed sequences add exact checks.
// Inputs are driven 1 time unit after the rising edge and outputs sampled on the falling edge.
module tb_irq_timer;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE + 32'h0;
    localparam logic [31:0] A_TL   = BASE + 32'h4;
    localparam logic [31:0] A_TCON = BASE + 32'h8;
    localparam logic [31:0] A_ICNT = BASE + 32'hC;

    logic        clk;
    logic        rst;
    logic        mr;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;

    irq_timer_if b1 ();
    irq_timer_if b4 ();

    assign b1.MemRead   = mr;
    assign b1.MemWrite  = mw;
    assign b1.Address   = addr;
    assign b1.WriteData = wd;
    assign b4.MemRead   = mr;
    assign b4.MemWrite  = mw;
    assign b4.Address   = addr;
    assign b4.WriteData = wd;

    irq_timer #(.PRESCALE(1), .BASE(BASE)) u_p1 (.clk(clk), .reset(rst), .bus(b1.slave));
    irq_timer #(.PRESCALE(4), .BASE(BASE)) u_p4 (.clk(clk), .reset(rst), .bus(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;

    // Reference model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4
    logic [31:0] m_th   [2];
    logic [31:0] m_tl   [2];
    logic [2:0]  m_tcon [2];
    int          m_icnt [2];
    longint      m_run  [2];   // enabled cycles since EN last rose

    logic [31:0] s_rd  [2];
    logic        s_irq [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a[31:2] >= BASE[31:2]) && (a[31:2] <= BASE[31:2] + 30'd3);
    endfunction

    function automatic logic [1:0] woff(input logic [31:0] a);
        logic [29:0] w;
        w = a[31:2] - BASE[31:2];
        return w[1:0];
    endfunction

    function automatic logic [31:0] m_read(input int k, input bit r, input logic [31:0] a);
        if (!r || !in_win(a)) return 32'd0;
        case (woff(a))
            2'd0:    return m_th[k];
            2'd1:    return m_tl[k];
            2'd2:    return {29'd0, m_tcon[k]};
            default: return 32'(m_icnt[k]);
        endcase
    endfunction

    task automatic m_reset(input int k);
        m_th[k] = 0; m_tl[k] = 0; m_tcon[k] = 0; m_icnt[k] = 0; m_run[k] = 0;
    endtask

    // One clock edge of the timer, expressed from the register-level rules
    task automatic m_step(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
        int          ps;
        bit          en;
        bit          tick;
        bit          wr;
        logic [1:0]  o;
        logic [2:0]  nt;
        logic [31:0] ntl;
        int          nic;
        ps = (k == 0) ? 1 : 4;
        if (rst) begin
            m_reset(k);
            return;
        end
        en   = m_tcon[k][0];
        tick = en && ((m_run[k] % ps) == longint'(ps - 1));
        wr   = w && in_win(a);
        o    = woff(a);
        nt   = m_tcon[k];
        if (wr && o == 2'd2) nt = d[2:0];
        ntl = m_tl[k];
        if (wr && o == 2'd1) ntl = d;
        else if (tick) ntl = (m_tl[k] == 32'hFFFF_FFFF) ? m_th[k] : m_tl[k] + 32'd1;
        nic = (wr && o == 2'd3) ? 0 : m_icnt[k];
        if (tick && m_tl[k] == 32'hFFFF_FFFF && nt[1]) begin
            nt[2] = 1'b1;
            if (nic < 255) nic++;
        end
        if (wr && o == 2'd0) m_th[k] = d;
        m_run[k]  = !nt[0] ? 0 : (en ? m_run[k] + 1 : 0);
        m_tl[k]   = ntl;
        m_tcon[k] = nt;
        m_icnt[k] = nic;
    endtask

    // Apply one bus cycle, compare both instances with the model, then advance the model
    task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        mr = r; mw = w; addr = a; wd = d;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            s_rd[k]  = (k == 0) ? b1.ReadData : b4.ReadData;
            s_irq[k] = (k == 0) ? b1.IRQ : b4.IRQ;
            chk(k == 0 ? "model_rd_p1" : "model_rd_p4", s_rd[k], m_read(k, r, a));
            chk(k == 0 ? "model_irq_p1" : "model_irq_p4", 32'(s_irq[k]),
                32'(m_tcon[k][1] & m_tcon[k][2]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) m_step(k, w, a, d);
        ncyc++;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] e, input bit ei);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.exp_rd = e; v.exp_irq = ei;
        return v;
    endfunction

    initial begin
        vec_t        tbl[$];
        int          first;
        int          c1;
        int          c2;
        int          reloads;
        logic [31:0] prev;
        bit          irq_seen;

        rst = 1'b1; mr = 1'b0; mw = 1'b0; addr = 32'd0; wd = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) m_reset(k);

        // ---------------- register access table (EN stays 0) ----------------
        tbl.push_back(mk(1, 0, A_TH,   0, 32'h0, 0));
        tbl.push_back(mk(1, 0, A_TL,   0, 32'h0, 0));
        tbl.push_back(mk(1, 0, A_TCON, 0, 32'h0, 0));
        tbl.push_back(mk(1, 0, A_ICNT, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, A_TH,   32'h1234_5678, 32'h0, 0));
        tbl.push_back(mk(1, 0, A_TH,   0, 32'h1234_5678, 0));
        tbl.push_back(mk(0, 1, A_TL,   32'h0000_ABCD, 32'h0, 0));
        tbl.push_back(mk(1, 0, A_TL,   0, 32'h0000_ABCD, 0));
        tbl.push_back(mk(1, 0, BASE + 32'h7, 0, 32'h0000_ABCD, 0));
        tbl.push_back(mk(0, 1, A_TCON, 32'hFFFF_FFF6, 32'h0, 0));
        tbl.push_back(mk(1, 0, A_TCON, 0, 32'h6, 1));
        tbl.push_back(mk(0, 1, A_TCON, 32'h2, 32'h0, 1));
        tbl.push_back(mk(1, 0, A_TCON, 0, 32'h2, 0));
        tbl.push_back(mk(1, 1, A_TH,   32'hCAFE_F00D, 32'h1234_5678, 0));
        tbl.push_back(mk(1, 0, A_TH,   0, 32'hCAFE_F00D, 0));
        tbl.push_back(mk(0, 1, BASE + 32'h10, 32'h55, 32'h0, 0));
        tbl.push_back(mk(1, 0, BASE + 32'h10, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'h0, 32'h77, 32'h0, 0));
        tbl.push_back(mk(1, 0, 32'h0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, A_TH,   0, 32'h0, 0));
        tbl.push_back(mk(1, 0, A_TH,   0, 32'hCAFE_F00D, 0));
        tbl.push_back(mk(1, 0, A_TCON, 0, 32'h2, 0));
        tbl.push_back(mk(0, 1, A_TCON, 32'h0, 32'h0, 0));
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_rd", i), s_rd[0], tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq", i), 32'(s_irq[0]), 32'(tbl[i].exp_irq));
        end
        repeat (100) idle();
        cyc(1, 0, A_TL, 0);
        chk("idle_tl_hold", s_rd[0], 32'h0000_ABCD);

        // ---------------- basic period, PRESCALE 1 ----------------
        do_reset();
        cyc(0, 1, A_TH, 32'hFFFF_FFFC);
        cyc(0, 1, A_TL, 32'hFFFF_FFFC);
        cyc(0, 1, A_TCON, 32'h3);
        first = -1; c1 = 0;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            cyc(1, 0, A_TL, 0);
            if (s_irq[0]) begin
                first = i - 1;
                c1 = ncyc;
                chk("p1_tl_reloaded", s_rd[0], 32'hFFFF_FFFC);
            end
        end
        chk("p1_irq_rise_edges", 32'(first), 32'd4);
        cyc(1, 0, A_ICNT, 0);
        chk("p1_icnt_1", s_rd[0], 32'd1);
        cyc(1, 1, A_TCON, 32'h3);
        chk("p1_tcon_prewrite", s_rd[0], 32'h7);
        cyc(1, 0, A_ICNT, 0);
        chk("p1_irq_fell", 32'(s_irq[0]), 32'd0);
        c2 = -1;
        for (int i = 0; i < 20 && c2 < 0; i++) begin
            cyc(1, 0, A_ICNT, 0);
            if (s_irq[0]) begin
                c2 = ncyc;
                chk("p1_icnt_2", s_rd[0], 32'd2);
            end
        end
        chk("p1_period", 32'(c2 - c1), 32'd4);

        // ---------------- prescale 4 ----------------
        do_reset();
        cyc(0, 1, A_TH, 32'hFFFF_FFFE);
        cyc(0, 1, A_TL, 32'hFFFF_FFFE);
        cyc(0, 1, A_TCON, 32'h3);
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 0, A_TL, 0);
            if (i == 4) chk("p4_tl_hold", s_rd[1], 32'hFFFF_FFFE);
            if (i == 5) chk("p4_tl_step", s_rd[1], 32'hFFFF_FFFF);
            if (i == 8) chk("p4_irq_low", 32'(s_irq[1]), 32'd0);
            if (i == 9) begin
                chk("p4_tl_reload", s_rd[1], 32'hFFFF_FFFE);
                chk("p4_irq_at_8", 32'(s_irq[1]), 32'd1);
            end
        end

        // ---------------- IE = 0 ----------------
        do_reset();
        cyc(0, 1, A_TH, 32'hFFFF_FFFD);
        cyc(0, 1, A_TL, 32'hFFFF_FFFD);
        cyc(0, 1, A_TCON, 32'h1);
        reloads = 0; irq_seen = 0; prev = 32'hFFFF_FFFD;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, A_TL, 0);
            if (prev == 32'hFFFF_FFFF && s_rd[0] == 32'hFFFF_FFFD) reloads++;
            if (s_irq[0]) irq_seen = 1;
            prev = s_rd[0];
        end
        chk("ie0_reloads", 32'(reloads), 32'd3);
        chk("ie0_no_irq", 32'(irq_seen), 32'd0);
        cyc(1, 0, A_ICNT, 0);
        chk("ie0_icnt", s_rd[0], 32'd0);

        // ---------------- collisions ----------------
        do_reset();
        cyc(0, 1, A_TL, 32'hFFFF_FFFE);
        cyc(0, 1, A_TCON, 32'h3);
        idle();
        cyc(0, 1, A_TCON, 32'h3);          // lands on the overflow edge
        cyc(1, 0, A_TCON, 0);
        chk("col_is_kept", s_rd[0], 32'h7);
        chk("col_irq_kept", 32'(s_irq[0]), 32'd1);
        cyc(0, 1, A_TL, 32'd5);            // every cycle is a tick at PRESCALE 1
        cyc(1, 0, A_TL, 0);
        chk("col_tl_write_wins", s_rd[0], 32'd5);
        cyc(0, 1, A_TH, 32'h20);
        cyc(0, 1, A_TL, 32'hFFFF_FFFF);
        cyc(0, 1, A_TH, 32'd10);           // overflow edge
        cyc(1, 0, A_TL, 0);
        chk("col_tl_old_th", s_rd[0], 32'h20);
        cyc(1, 0, A_TH, 0);
        chk("col_th_new", s_rd[0], 32'd10);
        rst = 1'b1;
        cyc(0, 1, A_TH, 32'hDEAD_BEEF);
        rst = 1'b0;
        cyc(1, 0, A_TH, 0);
        chk("rst_beats_write", s_rd[0], 32'd0);
        chk("rst_irq_low", 32'(s_irq[0]), 32'd0);

        // ---------------- saturation ----------------
        cyc(0, 1, A_TH, 32'hFFFF_FFFF);
        cyc(0, 1, A_TL, 32'hFFFF_FFFF);
        cyc(0, 1, A_TCON, 32'h3);
        repeat (1100) idle();
        cyc(1, 1, A_ICNT, 32'h1234);
        chk("sat_icnt_p1", s_rd[0], 32'd255);
        chk("sat_icnt_p4", s_rd[1], 32'd255);
        cyc(1, 0, A_ICNT, 0);
        chk("clr_with_inc", s_rd[0], 32'd1);
        cyc(0, 1, A_TCON, 32'h0);
        cyc(0, 1, A_ICNT, 32'h0);
        cyc(1, 0, A_ICNT, 0);
        chk("icnt_cleared", s_rd[0], 32'd0);

        // ---------------- randomized run against the model ----------------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [1:0]  o;
            bit          r;
            bit          w;
            rst = ($urandom_range(0, 299) == 0);
            r   = $urandom_range(0, 1) == 1;
            o   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = BASE + {28'd0, o, 2'($urandom_range(0, 3))};
            w = (o == 2'd2) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 5) == 0);
            case (o)
                2'd2:    d = $urandom();
                default: d = ($urandom_range(0, 3) == 0) ? $urandom()
                                                         : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            endcase
            cyc(r, w, a, d);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
